mux_arb_reg: RTL and testbench

- Parametrised, registered successor to the datapath muxes: selects one of N WIDTH-bit valid/ready source channels and forwards it through a single output register.
- Three selection modes:
  - forced: select-line driven, as the combinational muxes do.
  - fixed priority.
  - round-robin.
- Used where several producers share one datapath sink and must be stalled cleanly, e.g. shared writeback or memory request paths.

---
 rtl/mux_arb_reg.sv | 159 +++++++++++++++
 tb/tb_mux_arb_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - N-channel valid/ready arbiter (forced/fixed/round-robin) with registered output
module mux_arb_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SEL_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {
    MODE_FORCED = 2'b00,
    MODE_FIXED  = 2'b01,
    MODE_RR     = 2'b10
  } mode_e;

  localparam logic [SEL_W-1:0] RR_RESET = SEL_W'(N - 1);

  generate
    if (N < 2 || N > 16 || (1 << SEL_W) < N) begin : g_param_check
      $error("mux_arb_reg: N must be 2..16 and 2**SEL_W >= N");
    end
  endgenerate

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  mode_e            w_mode;
  logic             w_load_en;
  logic             w_forced_hit;
  logic [SEL_W-1:0] w_forced_idx;
  logic             w_fixed_hit;
  logic [SEL_W-1:0] w_fixed_idx;
  logic             w_rr_hit;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_grant_any;
  logic [SEL_W-1:0] w_grant_idx;
  logic [N-1:0]     w_grant;
  logic [WIDTH-1:0] w_grant_data;

  // Reserved encoding 11 falls back to fixed priority.
  always_comb begin
    case (mode)
      2'b00:   w_mode = MODE_FORCED;
      2'b10:   w_mode = MODE_RR;
      default: w_mode = MODE_FIXED;
    endcase
  end

  assign w_load_en = !r_out_valid || out_ready;

  // An out-of-range sel matches no channel, so it yields no grant.
  always_comb begin
    w_forced_hit = 1'b0;
    w_forced_idx = sel;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        w_forced_hit = in_valid[i];
      end
    end
  end

  always_comb begin
    w_fixed_hit = 1'b0;
    w_fixed_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_fixed_hit = 1'b1;
        w_fixed_idx = SEL_W'(i);
      end
    end
  end

  // Search starts one past the last granted channel and wraps modulo N.
  always_comb begin
    int c;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    c        = 0;
    for (int k = 1; k <= N; k++) begin
      c = int'(r_rr_ptr) + k;
      if (c >= N) begin
        c = c - N;
      end
      if (!w_rr_hit && in_valid[c]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = SEL_W'(c);
      end
    end
  end

  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    case (w_mode)
      MODE_FORCED: begin
        w_grant_any = w_forced_hit;
        w_grant_idx = w_forced_idx;
      end
      MODE_RR: begin
        w_grant_any = w_rr_hit;
        w_grant_idx = w_rr_idx;
      end
      default: begin
        w_grant_any = w_fixed_hit;
        w_grant_idx = w_fixed_idx;
      end
    endcase
  end

  always_comb begin
    w_grant      = '0;
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_any && (w_grant_idx == SEL_W'(i))) begin
        w_grant[i]   = 1'b1;
        w_grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (reset || !w_load_en) ? '0 : w_grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= RR_RESET;
    end else if (w_load_en) begin
      if (w_grant_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_chan  <= w_grant_idx;
        if (w_mode == MODE_RR) begin
          r_rr_ptr <= w_grant_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - self-checking bench for mux_arb_reg against a behavioural arbitration model
module tb_mux_arb_reg;
  localparam int N = 3;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic [1:0]     mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_chan;
  int           m_ptr;
  logic [N-1:0] exp_ready;
  logic [N-1:0] s_ready;

  logic [W-1:0] words [N];

  mux_arb_reg #(.WIDTH(W), .N(N), .SEL_W(2)) dut (
    .clock(clock), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Winner chosen straight from the arbitration rules; -1 means nobody.
  function automatic int pick(input logic [1:0] md, input int s, input logic [N-1:0] v, input int ptr);
    if (md == 2'b00) begin
      if (s < N && v[s]) return s;
      return -1;
    end
    if (md == 2'b10) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (v[c]) return c;
      end
      return -1;
    end
    for (int c = 0; c < N; c++) begin
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_words();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = words[i];
  endtask

  task automatic tick();
    int g;
    logic load;
    @(negedge clock);
    load = !m_valid || out_ready;
    g = pick(mode, int'(sel), in_valid, m_ptr);
    exp_ready = '0;
    if (!reset && load && g >= 0) exp_ready[g] = 1'b1;
    s_ready = in_ready;
    @(posedge clock);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_chan = '0; m_ptr = N - 1;
    end else if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_chan  = 2'(g);
        if (mode == 2'b10) m_ptr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    words[0] = 32'h55555555; words[1] = 32'h0000FFFF; words[2] = 32'hFFFF0000;
    set_words();
    reset = 1'b1; mode = 2'b00; sel = 2'd0; in_valid = 3'b111; out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", out_chan); end
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", s_ready); end
    reset = 1'b0;
  endtask

  task automatic test_forced();
    int seq [4] = '{0, 1, 2, 0};
    mode = 2'b00; in_valid = 3'b111; out_ready = 1'b1;
    for (int st = 0; st < 4; st++) begin
      sel = 2'(seq[st]);
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++; if (out_data !== words[seq[st]]) begin errors++; $display("FAIL forced_data: got %h expected %h", out_data, words[seq[st]]); end
        checks++; if (out_chan !== 2'(seq[st]) || out_valid !== 1'b1) begin errors++; $display("FAIL forced_chan: got %0d/%b expected %0d/1", out_chan, out_valid, seq[st]); end
        checks++; if (s_ready !== (3'b001 << seq[st])) begin errors++; $display("FAIL forced_ready: got %b expected %b", s_ready, 3'b001 << seq[st]); end
      end
    end
  endtask

  task automatic test_forced_nogrant();
    sel = 2'd3; in_valid = 3'b111;
    tick();
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL sel3_ready: got %b expected 000", s_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel3_valid: got %b expected 0", out_valid); end
    sel = 2'd2; in_valid = 3'b011;
    tick();
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL sel2_invalid_ready: got %b expected 000", s_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel2_invalid_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h55555555) begin errors++; $display("FAIL nogrant_hold: got %h expected 55555555", out_data); end
  endtask

  task automatic test_fixed();
    in_valid = 3'b110;
    for (int c = 0; c < 6; c++) begin
      mode = (c < 3) ? 2'b01 : 2'b11;
      tick();
      checks++; if (out_chan !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL fixed_chan: got %0d/%b expected 1/1", out_chan, out_valid); end
      checks++; if (s_ready !== 3'b010) begin errors++; $display("FAIL fixed_ready: got %b expected 010", s_ready); end
      checks++; if (out_data !== words[1]) begin errors++; $display("FAIL fixed_data: got %h expected %h", out_data, words[1]); end
    end
  endtask

  task automatic test_rr();
    int seq_a [6] = '{0, 1, 2, 0, 1, 2};
    int seq_b [4] = '{0, 2, 0, 2};
    mode = 2'b10; in_valid = 3'b111; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (out_chan !== 2'(seq_a[c]) || out_valid !== 1'b1) begin errors++; $display("FAIL rr_all_chan: got %0d/%b expected %0d/1", out_chan, out_valid, seq_a[c]); end
      checks++; if (out_data !== words[seq_a[c]]) begin errors++; $display("FAIL rr_all_data: got %h expected %h", out_data, words[seq_a[c]]); end
    end
    in_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_chan !== 2'(seq_b[c]) || out_valid !== 1'b1) begin errors++; $display("FAIL rr_101_chan: got %0d/%b expected %0d/1", out_chan, out_valid, seq_b[c]); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] held_chan;
    logic [W-1:0] held_data;
    int nxt;
    mode = 2'b10; in_valid = 3'b111; out_ready = 1'b1;
    tick();
    held_chan = m_chan; held_data = m_data;
    checks++; if (out_chan !== held_chan || out_data !== held_data) begin errors++; $display("FAIL bp_load: got %0d/%h expected %0d/%h", out_chan, out_data, held_chan, held_data); end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_chan !== held_chan || out_data !== held_data) begin
        errors++; $display("FAIL bp_stall_hold: got %b/%0d/%h expected 1/%0d/%h", out_valid, out_chan, out_data, held_chan, held_data);
      end
      checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL bp_stall_ready: got %b expected 000", s_ready); end
    end
    out_ready = 1'b1;
    nxt = (int'(held_chan) + 1) % N;
    tick();
    checks++; if (s_ready !== (3'b001 << nxt)) begin errors++; $display("FAIL bp_release_ready: got %b expected %b", s_ready, 3'b001 << nxt); end
    checks++; if (out_chan !== 2'(nxt) || out_data !== words[nxt] || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release_word: got %0d/%h expected %0d/%h", out_chan, out_data, nxt, words[nxt]);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    mode = 2'b10; in_valid = 3'b111; out_ready = 1'b1;
    for (int c = 0; c < 6 && !found; c++) begin
      tick();
      if (out_valid === 1'b1 && out_chan === 2'd1) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_find: channel 1 never delivered within 6 cycles, expected within 3"); end
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rst_mid_clear: got %b/%h expected 0/0", out_valid, out_data); end
    reset = 1'b0;
    tick();
    checks++; if (out_chan !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_first: got %0d/%b expected 0/1", out_chan, out_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      mode      = 2'($urandom_range(0, 3));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) words[i] = $urandom;
      set_words();
      tick();
      checks++; if (s_ready !== exp_ready) begin errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", c, s_ready, exp_ready); end
      checks++; if (out_valid !== m_valid || out_chan !== m_chan || out_data !== m_data) begin
        errors++; $display("FAIL rand_out: cycle %0d got %b/%0d/%h expected %b/%0d/%h", c, out_valid, out_chan, out_data, m_valid, m_chan, m_data);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    m_valid = 1'b0; m_data = '0; m_chan = '0; m_ptr = N - 1;
    test_reset();
    test_forced();
    test_forced_nogrant();
    test_fixed();
    test_rr();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
